// File: rtl/arb16_rr_if.sv
// Requester-side bundle for the 16-way round-robin arbiter.
// The slave modport is the arbiter; master is the requester/driver side.
interface arb16_rr_if;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        valid;
    logic        timeout;

    modport master (output req, output done,
                    input  sel, input grant, input valid, input timeout);
    modport slave  (input  req, input done,
                    output sel, output grant, output valid, output timeout);
endinterface

// File: rtl/arb16_rr.sv
// Round-robin arbiter for one shared mux16 datapath; sel feeds mux16.sel.
// All outputs registered; a grant ends on done, withdrawal or timeout.
module arb16_rr #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic      clk,
    input  logic      reset,
    arb16_rr_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    state_t          state_q, state_d;
    logic [3:0]      sel_q, sel_d;
    logic [15:0]     grant_q, grant_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      last_q, last_d;
    logic            pick_vld;
    logic [3:0]      pick_idx;
    logic [3:0]      idx;

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 4'd0;
        idx      = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            idx = last_q + 4'(k);
            if (!pick_vld && bus.req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (pick_vld) begin
                    sel_d   = pick_idx;
                    grant_d = 16'(1) << pick_idx;
                    valid_d = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.done || !bus.req[sel_q] ||
                    (TIMEOUT != 0 && cnt_q == TO_CNT)) begin
                    // done and withdrawal take precedence over the timeout pulse
                    timeout_d = !bus.done && bus.req[sel_q];
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    last_d    = sel_q;
                    state_d   = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= 4'd0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= 4'd15;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.grant   = grant_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_arb16_rr.sv
// Directed vector bench for arb16_rr built with TIMEOUT=4.
// Each row: inputs for the next edge, outputs expected just after it.
module tb_arb16_rr;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   nvec  = 0;
    int   nerr  = 0;

    arb16_rr_if bus();

    arb16_rr #(.TIMEOUT(4), .CW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] req;
        logic        done;
        logic [3:0]  sel;
        logic [15:0] grant;
        logic        valid;
        logic        tmo;
    } vec_t;

    vec_t tbl [27];

    task automatic check(input string name, input logic [3:0] sel,
                         input logic [15:0] grant, input logic valid, input logic tmo);
        nvec++;
        if (bus.sel !== sel || bus.grant !== grant || bus.valid !== valid || bus.timeout !== tmo) begin
            nerr++;
            $display("FAIL %s: got sel=%0d grant=%h valid=%b timeout=%b, want sel=%0d grant=%h valid=%b timeout=%b",
                     name, bus.sel, bus.grant, bus.valid, bus.timeout, sel, grant, valid, tmo);
        end
    endtask

    initial begin
        //             req       done  sel    grant     v     tmo
        tbl[0]  = '{16'h0001, 1'b0, 4'd0,  16'h0001, 1'b1, 1'b0}; // first grant to 0
        tbl[1]  = '{16'h0001, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b0}; // done releases
        tbl[2]  = '{16'h0001, 1'b0, 4'd0,  16'h0001, 1'b1, 1'b0}; // sole requester regranted
        tbl[3]  = '{16'h8001, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b0};
        tbl[4]  = '{16'h8001, 1'b0, 4'd15, 16'h8000, 1'b1, 1'b0}; // rotate to 15
        tbl[5]  = '{16'h8001, 1'b1, 4'd15, 16'h0000, 1'b0, 1'b0};
        tbl[6]  = '{16'h8001, 1'b0, 4'd0,  16'h0001, 1'b1, 1'b0}; // wrap 15->0
        tbl[7]  = '{16'h8001, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b0};
        tbl[8]  = '{16'h8001, 1'b0, 4'd15, 16'h8000, 1'b1, 1'b0};
        tbl[9]  = '{16'h0006, 1'b1, 4'd15, 16'h0000, 1'b0, 1'b0};
        tbl[10] = '{16'h0006, 1'b0, 4'd1,  16'h0002, 1'b1, 1'b0}; // 15->0->1
        tbl[11] = '{16'h0000, 1'b0, 4'd1,  16'h0000, 1'b0, 1'b0}; // owner withdrew
        tbl[12] = '{16'h0020, 1'b0, 4'd5,  16'h0020, 1'b1, 1'b0}; // cnt=1
        tbl[13] = '{16'h0020, 1'b0, 4'd5,  16'h0020, 1'b1, 1'b0};
        tbl[14] = '{16'h0020, 1'b0, 4'd5,  16'h0020, 1'b1, 1'b0};
        tbl[15] = '{16'h0020, 1'b0, 4'd5,  16'h0020, 1'b1, 1'b0}; // 4th valid cycle
        tbl[16] = '{16'h0020, 1'b0, 4'd5,  16'h0000, 1'b0, 1'b1}; // timeout pulse
        tbl[17] = '{16'h0020, 1'b0, 4'd5,  16'h0020, 1'b1, 1'b0}; // pulse gone, regrant
        tbl[18] = '{16'h0000, 1'b0, 4'd5,  16'h0000, 1'b0, 1'b0};
        tbl[19] = '{16'h0008, 1'b0, 4'd3,  16'h0008, 1'b1, 1'b0};
        tbl[20] = '{16'h0200, 1'b0, 4'd3,  16'h0000, 1'b0, 1'b0}; // 3 drops mid-grant
        tbl[21] = '{16'h0200, 1'b0, 4'd9,  16'h0200, 1'b1, 1'b0};
        tbl[22] = '{16'h0200, 1'b0, 4'd9,  16'h0200, 1'b1, 1'b0};
        tbl[23] = '{16'h02FF, 1'b0, 4'd9,  16'h0200, 1'b1, 1'b0}; // non-owner churn ignored
        tbl[24] = '{16'h0200, 1'b0, 4'd9,  16'h0200, 1'b1, 1'b0}; // cnt=4
        tbl[25] = '{16'h0200, 1'b1, 4'd9,  16'h0000, 1'b0, 1'b0}; // done beats timeout
        tbl[26] = '{16'h0000, 1'b1, 4'd9,  16'h0000, 1'b0, 1'b0}; // done in IDLE ignored

        bus.req  = '0;
        bus.done = 1'b0;
        #2;
        check("reset_state", 4'd0, 16'h0000, 1'b0, 1'b0);
        #10;
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_no_req", 4'd0, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 27; i++) begin
            bus.req  = tbl[i].req;
            bus.done = tbl[i].done;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].grant, tbl[i].valid, tbl[i].tmo);
        end

        // Async reset mid-grant, then arbitration restarts at requester 0.
        bus.req  = 16'h0010;
        bus.done = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_grant", 4'd4, 16'h0010, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 4'd0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("reset_held", 4'd0, 16'h0000, 1'b0, 1'b0);
        reset   = 1'b0;
        bus.req = 16'hFFFF;
        @(posedge clk); #1;
        check("post_reset_first", 4'd0, 16'h0001, 1'b1, 1'b0);
        bus.done = 1'b1;
        @(posedge clk); #1;
        bus.done = 1'b0;
        check("post_reset_release", 4'd0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("post_reset_next", 4'd1, 16'h0002, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
